oob_link_sched: RTL and testbench

//  Link bring-up scheduler that sequences the OOB engine: issues oob_start, retries with backoff
//  on oob_error/oob_silence, steps the line rate down on repeated failure or oob_incompatible,
//  and re-trains after link_down. Sits between the host control block and the OOB/GTX path;

---
 rtl/oob_link_sched_pkg.sv | 30 +++
 rtl/oob_sched_timer.sv | 34 +++
 rtl/oob_link_sched.sv | 248 ++++++++++++++++++++++++
 tb/tb_oob_link_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oob_link_sched_pkg.sv
// rtl/oob_link_sched_pkg.sv - shared types and constants for the OOB link scheduler
// Purpose : FSM state encoding, line-rate codes, timer width and a saturating
//           counter helper used by oob_link_sched and oob_sched_timer.
// Ports   : none (package)
package oob_link_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_BUSY      = 3'd2,
      ST_BACKOFF   = 3'd3,
      ST_RATE_DOWN = 3'd4,
      ST_WAIT_GTX  = 3'd5,
      ST_LINKED    = 3'd6,
      ST_FAIL      = 3'd7
   } state_t;

   // Line-rate codes on speed_sel; 0 is always the slowest rate.
   localparam logic [1:0] SPEED_GEN1 = 2'd0;
   localparam logic [1:0] SPEED_GEN2 = 2'd1;
   localparam logic [1:0] SPEED_GEN3 = 2'd2;
   localparam logic [1:0] SPEED_MAX  = SPEED_GEN3;

   localparam int TMR_W = 32;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/oob_sched_timer.sv
// rtl/oob_sched_timer.sv - loadable down-counter with zero flag
// Purpose : single wait timer shared by the BACKOFF and WAIT_GTX states.
// Ports   : i_clk       clock
//           i_rst       synchronous active-high reset (count cleared)
//           i_load      load i_load_val this cycle (takes priority over counting)
//           i_load_val  value to load
//           o_zero      count has reached zero
module oob_sched_timer
   import oob_link_sched_pkg::*;
#(
   parameter int W = TMR_W
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/oob_link_sched.sv
// rtl/oob_link_sched.sv - link bring-up scheduler sequencing the OOB engine
// Purpose : issues oob_start, retries with backoff on error/silence, steps the
//           line rate down on repeated failure or incompatibility, retrains after
//           link_down, and owns phy_ready, speed_sel and GTX reset requests.
// Build   : define OOB_LINK_SCHED_STATS_EN to build the statistics counters;
//           otherwise o_stat_* are tied to zero.
// Ports   : i_clk/i_rst            clock, synchronous active-high reset
//           i_gtx_ready            all GTX resets done
//           i_rxbyteisaligned      GTX comma alignment (resynchronised here)
//           i_link_up/i_link_down  OOB engine link status events
//           i_oob_error/i_oob_silence/i_oob_incompatible  OOB failure events
//           i_cominit_req          device-initiated COMINIT seen
//           i_restart              pulse: leave FAIL at the fastest rate
//           o_oob_start            pulse: begin an OOB sequence
//           o_cominit_allow        OOB engine may answer device COMINIT
//           o_speed_sel[1:0]       rate select, 0 = slowest
//           o_gtx_reset_req        pulse: reset GTX after a rate change
//           o_phy_ready/o_link_fail  link usable / all rates exhausted
//           o_state_dbg[2:0]       current FSM state
//           o_stat_retries/o_stat_linkdowns[15:0]  saturating event counts
module oob_link_sched
   import oob_link_sched_pkg::*;
#(
   parameter int CLK_SPEED_GRADE = 2,
   parameter int MAX_RETRIES     = 4,
   parameter int BACKOFF_CYCLES  = 1024,
   parameter int SETTLE_CYCLES   = 64,
   parameter int NUM_SPEEDS      = 3
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_gtx_ready,
   input  logic        i_rxbyteisaligned,
   input  logic        i_link_up,
   input  logic        i_link_down,
   input  logic        i_oob_error,
   input  logic        i_oob_silence,
   input  logic        i_oob_incompatible,
   input  logic        i_cominit_req,
   input  logic        i_restart,
   output logic        o_oob_start,
   output logic        o_cominit_allow,
   output logic [1:0]  o_speed_sel,
   output logic        o_gtx_reset_req,
   output logic        o_phy_ready,
   output logic        o_link_fail,
   output logic [2:0]  o_state_dbg,
   output logic [15:0] o_stat_retries,
   output logic [15:0] o_stat_linkdowns
);

   localparam int RW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);
   localparam logic [1:0] SPEED_TOP = 2'(NUM_SPEEDS - 1);

   // The timer loads one cycle after the state is entered and the exit happens on
   // the edge after it reads zero, so two cycles are taken off the load value to
   // make the state last exactly the requested number of cycles.
   localparam int BACKOFF_TOTAL = BACKOFF_CYCLES * CLK_SPEED_GRADE;
   localparam logic [TMR_W-1:0] BACKOFF_LOAD =
      (BACKOFF_TOTAL > 2) ? TMR_W'(BACKOFF_TOTAL - 2) : '0;
   localparam logic [TMR_W-1:0] SETTLE_LOAD =
      (SETTLE_CYCLES > 2) ? TMR_W'(SETTLE_CYCLES - 2) : '0;

   state_t            r_state;
   logic [RW-1:0]     r_retry_cnt;
   logic [1:0]        r_speed_sel;
   logic              r_oob_start;
   logic              r_cominit_allow;
   logic              r_gtx_reset_req;
   logic              r_phy_ready;
   logic              r_link_fail;
   logic              r_tmr_load;
   logic [TMR_W-1:0]  r_tmr_val;
   logic              r_rx_r;
   logic              r_rx_rr;
   logic              w_tmr_zero;
   logic              w_tmr_done;
`ifdef OOB_LINK_SCHED_STATS_EN
   logic [15:0]       r_stat_retries;
   logic [15:0]       r_stat_linkdowns;
`endif

   oob_sched_timer #(.W(TMR_W)) u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (r_tmr_load),
      .i_load_val (r_tmr_val),
      .o_zero     (w_tmr_zero)
   );

   // A zero count is stale while a load is still pending.
   assign w_tmr_done = w_tmr_zero & ~r_tmr_load;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_r  <= 1'b0;
         r_rx_rr <= 1'b0;
      end else begin
         r_rx_r  <= i_rxbyteisaligned;
         r_rx_rr <= r_rx_r;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= ST_IDLE;
         r_retry_cnt     <= '0;
         r_speed_sel     <= SPEED_TOP;
         r_oob_start     <= 1'b0;
         r_cominit_allow <= 1'b0;
         r_gtx_reset_req <= 1'b0;
         r_phy_ready     <= 1'b0;
         r_link_fail     <= 1'b0;
         r_tmr_load      <= 1'b0;
         r_tmr_val       <= '0;
`ifdef OOB_LINK_SCHED_STATS_EN
         r_stat_retries   <= 16'h0;
         r_stat_linkdowns <= 16'h0;
`endif
      end else begin
         r_oob_start     <= 1'b0;
         r_gtx_reset_req <= 1'b0;
         r_tmr_load      <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (i_gtx_ready) begin
                  r_state     <= ST_START;
                  r_oob_start <= 1'b1;
               end
            end

            ST_START: begin
               if (!i_gtx_ready) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_BUSY;
               end
            end

            ST_BUSY: begin
               if (!i_gtx_ready) begin
                  r_state <= ST_IDLE;
               end else if (i_link_up) begin
                  r_state         <= ST_LINKED;
                  r_retry_cnt     <= '0;
                  r_cominit_allow <= 1'b1;
               end else if (i_oob_incompatible) begin
                  r_state <= ST_RATE_DOWN;
               end else if (i_oob_error || i_oob_silence) begin
                  r_retry_cnt <= r_retry_cnt + 1'b1;
`ifdef OOB_LINK_SCHED_STATS_EN
                  r_stat_retries <= sat_inc16(r_stat_retries);
`endif
                  if (r_retry_cnt >= RETRY_LAST) begin
                     r_state <= ST_RATE_DOWN;
                  end else begin
                     r_state         <= ST_BACKOFF;
                     r_cominit_allow <= 1'b1;
                     r_tmr_load      <= 1'b1;
                     r_tmr_val       <= BACKOFF_LOAD;
                  end
               end
            end

            ST_BACKOFF: begin
               if (!i_gtx_ready) begin
                  r_state         <= ST_IDLE;
                  r_cominit_allow <= 1'b0;
               end else if (i_cominit_req || w_tmr_done) begin
                  r_state         <= ST_START;
                  r_oob_start     <= 1'b1;
                  r_cominit_allow <= 1'b0;
               end
            end

            ST_RATE_DOWN: begin
               r_retry_cnt <= '0;
               if (r_speed_sel == SPEED_GEN1) begin
                  r_state     <= ST_FAIL;
                  r_link_fail <= 1'b1;
               end else begin
                  r_state         <= ST_WAIT_GTX;
                  r_speed_sel     <= r_speed_sel - 2'd1;
                  r_gtx_reset_req <= 1'b1;
                  r_tmr_load      <= 1'b1;
                  r_tmr_val       <= SETTLE_LOAD;
               end
            end

            ST_WAIT_GTX: begin
               if (w_tmr_done && i_gtx_ready) begin
                  r_state     <= ST_START;
                  r_oob_start <= 1'b1;
               end
            end

            ST_LINKED: begin
               r_phy_ready <= i_gtx_ready & r_rx_rr;
               if (!i_gtx_ready) begin
                  r_state         <= ST_IDLE;
                  r_cominit_allow <= 1'b0;
                  r_phy_ready     <= 1'b0;
               end else if (i_link_down) begin
                  r_state     <= ST_BACKOFF;
                  r_retry_cnt <= '0;
                  r_phy_ready <= 1'b0;
                  r_tmr_load  <= 1'b1;
                  r_tmr_val   <= BACKOFF_LOAD;
`ifdef OOB_LINK_SCHED_STATS_EN
                  r_stat_linkdowns <= sat_inc16(r_stat_linkdowns);
`endif
               end
            end

            ST_FAIL: begin
               if (i_restart) begin
                  r_state     <= ST_IDLE;
                  r_speed_sel <= SPEED_TOP;
                  r_retry_cnt <= '0;
                  r_link_fail <= 1'b0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_oob_start      = r_oob_start;
   assign o_cominit_allow  = r_cominit_allow;
   assign o_speed_sel      = r_speed_sel;
   assign o_gtx_reset_req  = r_gtx_reset_req;
   assign o_phy_ready      = r_phy_ready;
   assign o_link_fail      = r_link_fail;
   assign o_state_dbg      = r_state;
`ifdef OOB_LINK_SCHED_STATS_EN
   assign o_stat_retries   = r_stat_retries;
   assign o_stat_linkdowns = r_stat_linkdowns;
`else
   assign o_stat_retries   = 16'h0;
   assign o_stat_linkdowns = 16'h0;
`endif

endmodule

// File: tb/tb_oob_link_sched.sv
// tb/tb_oob_link_sched.sv - self-checking bench for oob_link_sched
module tb_oob_link_sched;

   localparam int MAX_R   = 2;
   localparam int BACKOFF = 16;
   localparam int SETTLE  = 8;

   localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_BUSY = 3'd2, S_BACKOFF = 3'd3;
   localparam logic [2:0] S_RATE_DOWN = 3'd4, S_WAIT_GTX = 3'd5, S_LINKED = 3'd6, S_FAIL = 3'd7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        gtx_ready = 1'b0, rxaligned = 1'b0, link_up = 1'b0, link_down = 1'b0;
   logic        oob_error = 1'b0, oob_silence = 1'b0, oob_incompat = 1'b0;
   logic        cominit_req = 1'b0, restart = 1'b0;
   logic        oob_start, cominit_allow, gtx_reset_req, phy_ready, link_fail;
   logic [1:0]  speed_sel;
   logic [2:0]  state_dbg;
   logic [15:0] stat_retries, stat_linkdowns;

   int errors = 0;
   int checks = 0;

   // Reference model: rate, consecutive failures at this rate, event totals.
   int m_speed = 2;
   int m_retry = 0;
   int m_sr    = 0;
   int m_ld    = 0;

   oob_link_sched #(
      .CLK_SPEED_GRADE(1), .MAX_RETRIES(MAX_R), .BACKOFF_CYCLES(BACKOFF),
      .SETTLE_CYCLES(SETTLE), .NUM_SPEEDS(3)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_gtx_ready(gtx_ready), .i_rxbyteisaligned(rxaligned),
      .i_link_up(link_up), .i_link_down(link_down), .i_oob_error(oob_error),
      .i_oob_silence(oob_silence), .i_oob_incompatible(oob_incompat),
      .i_cominit_req(cominit_req), .i_restart(restart),
      .o_oob_start(oob_start), .o_cominit_allow(cominit_allow), .o_speed_sel(speed_sel),
      .o_gtx_reset_req(gtx_reset_req), .o_phy_ready(phy_ready), .o_link_fail(link_fail),
      .o_state_dbg(state_dbg), .o_stat_retries(stat_retries), .o_stat_linkdowns(stat_linkdowns)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] exp_sr();
`ifdef OOB_LINK_SCHED_STATS_EN
      return (m_sr > 65535) ? 16'hFFFF : 16'(m_sr);
`else
      return 16'h0;
`endif
   endfunction

   function automatic logic [15:0] exp_ld();
`ifdef OOB_LINK_SCHED_STATS_EN
      return (m_ld > 65535) ? 16'hFFFF : 16'(m_ld);
`else
      return 16'h0;
`endif
   endfunction

   task automatic wait_start(input int max_c, output int n);
      n = 0;
      while (oob_start !== 1'b1 && n < max_c) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_IDLE); end
      checks++; if (speed_sel !== 2'd2) begin errors++; $display("FAIL reset_speed: got %0d want 2", speed_sel); end
      checks++; if ({oob_start, cominit_allow, gtx_reset_req, phy_ready, link_fail} !== 5'b0) begin
         errors++; $display("FAIL reset_outputs: got %b want 00000", {oob_start, cominit_allow, gtx_reset_req, phy_ready, link_fail}); end
      checks++; if ({stat_retries, stat_linkdowns} !== 32'h0) begin
         errors++; $display("FAIL reset_stats: got %h/%h want 0/0", stat_retries, stat_linkdowns); end
   endtask

   task automatic test_happy_path();
      int n, d;
      gtx_ready = 1'b1;
      wait_start(5, n);
      checks++; if (n !== 1) begin errors++; $display("FAIL happy_start_latency: got %0d want 1", n); end
      tick();
      checks++; if (oob_start !== 1'b0 || state_dbg !== S_BUSY) begin
         errors++; $display("FAIL happy_start_pulse: start=%b state=%0d want 0/%0d", oob_start, state_dbg, S_BUSY); end
      d = $urandom_range(1, 6);
      repeat (d - 1) tick();
      link_up = 1'b1; tick(); link_up = 1'b0;
      m_retry = 0;
      checks++; if (state_dbg !== S_LINKED || cominit_allow !== 1'b1 || phy_ready !== 1'b0) begin
         errors++; $display("FAIL happy_linked: state=%0d allow=%b phy=%b want %0d/1/0", state_dbg, cominit_allow, phy_ready, S_LINKED); end
      rxaligned = 1'b1;
      n = 0;
      while (phy_ready !== 1'b1 && n < 6) begin tick(); n++; end
      checks++; if (n < 2 || n > 3) begin errors++; $display("FAIL happy_phy_latency: got %0d want 2..3", n); end
   endtask

   task automatic test_link_down();
      int n;
      link_down = 1'b1; tick(); link_down = 1'b0;
      m_ld++; m_retry = 0;
      checks++; if (phy_ready !== 1'b0 || state_dbg !== S_BACKOFF) begin
         errors++; $display("FAIL linkdown_state: phy=%b state=%0d want 0/%0d", phy_ready, state_dbg, S_BACKOFF); end
      checks++; if (stat_linkdowns !== exp_ld()) begin errors++; $display("FAIL linkdown_stat: got %0d want %0d", stat_linkdowns, exp_ld()); end
      wait_start(40, n);
      checks++; if (n !== BACKOFF) begin errors++; $display("FAIL linkdown_backoff: got %0d want %0d", n, BACKOFF); end
      tick();
   endtask

   task automatic test_retry();
      int n;
      if ($urandom_range(0, 1) == 0) oob_silence = 1'b1; else oob_error = 1'b1;
      tick();
      oob_silence = 1'b0; oob_error = 1'b0;
      m_retry++; m_sr++;
      checks++; if (state_dbg !== S_BACKOFF || cominit_allow !== 1'b1) begin
         errors++; $display("FAIL retry_state: state=%0d allow=%b want %0d/1", state_dbg, cominit_allow, S_BACKOFF); end
      checks++; if (stat_retries !== exp_sr()) begin errors++; $display("FAIL retry_stat: got %0d want %0d", stat_retries, exp_sr()); end
      wait_start(40, n);
      checks++; if (n !== BACKOFF) begin errors++; $display("FAIL retry_backoff: got %0d want %0d", n, BACKOFF); end
      tick();
   endtask

   // Entered one cycle after the failure that should send the FSM to RATE_DOWN.
   task automatic rate_down_path();
      int n;
      checks++; if (state_dbg !== S_RATE_DOWN) begin errors++; $display("FAIL ratedown_state: got %0d want %0d", state_dbg, S_RATE_DOWN); end
      m_retry = 0;
      tick();
      if (m_speed == 0) begin
         checks++; if (state_dbg !== S_FAIL || link_fail !== 1'b1) begin
            errors++; $display("FAIL exhaust_fail: state=%0d link_fail=%b want %0d/1", state_dbg, link_fail, S_FAIL); end
         link_up = 1'b1; cominit_req = 1'b1;
         repeat (3) tick();
         link_up = 1'b0; cominit_req = 1'b0;
         checks++; if (state_dbg !== S_FAIL || oob_start !== 1'b0) begin
            errors++; $display("FAIL fail_hold: state=%0d start=%b want %0d/0", state_dbg, oob_start, S_FAIL); end
         restart = 1'b1; tick(); restart = 1'b0;
         m_speed = 2;
         checks++; if (state_dbg !== S_IDLE || speed_sel !== 2'd2 || link_fail !== 1'b0) begin
            errors++; $display("FAIL restart_exit: state=%0d speed=%0d link_fail=%b want %0d/2/0", state_dbg, speed_sel, link_fail, S_IDLE); end
         wait_start(5, n);
         checks++; if (n !== 1) begin errors++; $display("FAIL restart_start: got %0d want 1", n); end
      end else begin
         m_speed--;
         checks++; if (gtx_reset_req !== 1'b1 || speed_sel !== 2'(m_speed) || state_dbg !== S_WAIT_GTX) begin
            errors++; $display("FAIL ratedown_step: req=%b speed=%0d state=%0d want 1/%0d/%0d", gtx_reset_req, speed_sel, state_dbg, m_speed, S_WAIT_GTX); end
         wait_start(30, n);
         checks++; if (n < SETTLE || n > SETTLE + 2) begin errors++; $display("FAIL ratedown_settle: got %0d want %0d..%0d", n, SETTLE, SETTLE + 2); end
      end
      tick();
   endtask

   task automatic test_rate_fallback();
      int n, h;
      bit early;
      oob_error = 1'b1; tick(); oob_error = 1'b0;
      m_retry++; m_sr++;
      checks++; if (state_dbg !== S_RATE_DOWN) begin errors++; $display("FAIL fallback_state: got %0d want %0d", state_dbg, S_RATE_DOWN); end
      m_retry = 0;
      tick();
      m_speed--;
      checks++; if (gtx_reset_req !== 1'b1 || speed_sel !== 2'(m_speed)) begin
         errors++; $display("FAIL fallback_step: req=%b speed=%0d want 1/%0d", gtx_reset_req, speed_sel, m_speed); end
      gtx_ready = 1'b0;
      h = $urandom_range(10, 14);
      early = 1'b0;
      repeat (h) begin tick(); if (oob_start === 1'b1 || gtx_reset_req === 1'b1) early = 1'b1; end
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL fallback_gate: early start/req seen=%b want 0", early); end
      gtx_ready = 1'b1;
      wait_start(5, n);
      checks++; if (n !== 1) begin errors++; $display("FAIL fallback_start: got %0d want 1", n); end
      checks++; if (stat_retries !== exp_sr()) begin errors++; $display("FAIL fallback_stat: got %0d want %0d", stat_retries, exp_sr()); end
      tick();
   endtask

   task automatic test_cominit();
      int k;
      oob_silence = 1'b1; tick(); oob_silence = 1'b0;
      m_retry++; m_sr++;
      k = $urandom_range(1, 10);
      repeat (k) tick();
      checks++; if (oob_start !== 1'b0 || state_dbg !== S_BACKOFF) begin
         errors++; $display("FAIL cominit_pre: start=%b state=%0d want 0/%0d", oob_start, state_dbg, S_BACKOFF); end
      cominit_req = 1'b1; tick(); cominit_req = 1'b0;
      checks++; if (oob_start !== 1'b1 || state_dbg !== S_START) begin
         errors++; $display("FAIL cominit_start: start=%b state=%0d want 1/%0d", oob_start, state_dbg, S_START); end
      tick();
   endtask

   task automatic test_collision();
      link_up = 1'b1; oob_error = 1'b1; tick(); link_up = 1'b0; oob_error = 1'b0;
      m_retry = 0;
      checks++; if (state_dbg !== S_LINKED) begin errors++; $display("FAIL collision_state: got %0d want %0d", state_dbg, S_LINKED); end
      checks++; if (stat_retries !== exp_sr()) begin errors++; $display("FAIL collision_stat: got %0d want %0d", stat_retries, exp_sr()); end
      test_link_down();
   endtask

   task automatic test_exhaustion();
      int guard = 0;
      bit done = 1'b0;
      while (!done && guard < 4) begin
         oob_incompat = 1'b1; tick(); oob_incompat = 1'b0;
         if (m_speed == 0) done = 1'b1;
         rate_down_path();
         guard++;
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL exhaust_reach: done=%b want 1", done); end
   endtask

   task automatic test_restart_ignored();
      restart = 1'b1; tick(); restart = 1'b0;
      checks++; if (state_dbg !== S_BUSY || speed_sel !== 2'(m_speed)) begin
         errors++; $display("FAIL restart_ignored: state=%0d speed=%0d want %0d/%0d", state_dbg, speed_sel, S_BUSY, m_speed); end
   endtask

   task automatic test_gtx_drop();
      int n;
      gtx_ready = 1'b0; oob_error = 1'b1; tick(); oob_error = 1'b0;
      checks++; if (state_dbg !== S_IDLE || stat_retries !== exp_sr()) begin
         errors++; $display("FAIL gtxdrop_busy: state=%0d stat=%0d want %0d/%0d", state_dbg, stat_retries, S_IDLE, exp_sr()); end
      gtx_ready = 1'b1;
      wait_start(5, n); tick();
      link_up = 1'b1; tick(); link_up = 1'b0;
      m_retry = 0;
      n = 0;
      while (phy_ready !== 1'b1 && n < 5) begin tick(); n++; end
      checks++; if (phy_ready !== 1'b1) begin errors++; $display("FAIL gtxdrop_phy_up: got %b want 1", phy_ready); end
      gtx_ready = 1'b0; tick();
      checks++; if (phy_ready !== 1'b0 || state_dbg !== S_IDLE || cominit_allow !== 1'b0) begin
         errors++; $display("FAIL gtxdrop_linked: phy=%b state=%0d allow=%b want 0/%0d/0", phy_ready, state_dbg, cominit_allow, S_IDLE); end
      gtx_ready = 1'b1;
      wait_start(5, n);
      checks++; if (n !== 1) begin errors++; $display("FAIL gtxdrop_restart: got %0d want 1", n); end
      tick();
   endtask

   task automatic test_random();
      int ev, n;
      for (int i = 0; i < 16; i++) begin
         ev = $urandom_range(0, 3);
         if (ev == 0) begin
            link_up = 1'b1; tick(); link_up = 1'b0;
            m_retry = 0;
            checks++; if (state_dbg !== S_LINKED) begin errors++; $display("FAIL rand_linked[%0d]: got %0d want %0d", i, state_dbg, S_LINKED); end
            test_link_down();
         end else if (ev == 3) begin
            oob_incompat = 1'b1; tick(); oob_incompat = 1'b0;
            rate_down_path();
         end else begin
            if (ev == 1) oob_error = 1'b1; else oob_silence = 1'b1;
            tick();
            oob_error = 1'b0; oob_silence = 1'b0;
            m_retry++; m_sr++;
            if (m_retry >= MAX_R) begin
               rate_down_path();
            end else begin
               checks++; if (state_dbg !== S_BACKOFF) begin errors++; $display("FAIL rand_backoff[%0d]: got %0d want %0d", i, state_dbg, S_BACKOFF); end
               wait_start(40, n);
               checks++; if (n !== BACKOFF) begin errors++; $display("FAIL rand_wait[%0d]: got %0d want %0d", i, n, BACKOFF); end
               tick();
            end
         end
         checks++; if (speed_sel !== 2'(m_speed) || stat_retries !== exp_sr() || state_dbg !== S_BUSY) begin
            errors++; $display("FAIL rand_track[%0d]: speed=%0d stat=%0d state=%0d want %0d/%0d/%0d", i, speed_sel, stat_retries, state_dbg, m_speed, exp_sr(), S_BUSY); end
      end
   endtask

   task automatic test_rst_wins();
      rst = 1'b1; link_up = 1'b1; oob_incompat = 1'b1; tick();
      rst = 1'b0; link_up = 1'b0; oob_incompat = 1'b0;
      m_speed = 2; m_retry = 0; m_sr = 0; m_ld = 0;
      checks++; if (state_dbg !== S_IDLE || speed_sel !== 2'd2 || oob_start !== 1'b0) begin
         errors++; $display("FAIL rst_wins: state=%0d speed=%0d start=%b want %0d/2/0", state_dbg, speed_sel, oob_start, S_IDLE); end
      checks++; if ({stat_retries, stat_linkdowns} !== {exp_sr(), exp_ld()}) begin
         errors++; $display("FAIL rst_stats: got %h/%h want 0/0", stat_retries, stat_linkdowns); end
   endtask

   initial begin
      test_reset();
      test_happy_path();
      test_link_down();
      test_retry();
      test_rate_fallback();
      test_cominit();
      test_collision();
      test_exhaustion();
      test_restart_ignored();
      test_gtx_drop();
      test_random();
      test_rst_wins();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
